// File: rtl/uart_tx_sched.sv
// Transmit sequencer between the UART TX FIFO and the transmitter: pop, load, start, track busy, then gap.
// Optional feature macro UART_TX_SCHED_STATS_EN adds a saturating frame_cnt output.

module uart_tx_sched #(
  parameter int DATA_WIDTH   = 16,
  parameter int GAP_WIDTH    = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  input  logic                  empty_tx,
  input  logic [DATA_WIDTH-1:0] tx_dout_fifo,
  output logic                  rd_en,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  tx_done,
  output logic                  sched_busy,
  output logic                  start_err,
  input  logic                  err_clr
`ifdef UART_TX_SCHED_STATS_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  localparam int TO_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    LOAD      = 3'd2,
    START     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5,
    GAP       = 3'd6
  } state_t;

  state_t                 state_r;
  logic                   rd_en_r;
  logic                   tx_start_r;
  logic [7:0]             tx_data_r;
  logic                   tx_done_r;
  logic                   sched_busy_r;
  logic                   start_err_r;
  logic [TO_W-1:0]        to_cnt_r;
  logic [GAP_WIDTH-1:0]   gap_cnt_r;
  logic                   unused_fifo_bits;

  // Only the low byte of the FIFO word is transmitted.
  assign unused_fifo_bits = ^tx_dout_fifo[DATA_WIDTH-1:8];

  // Scheduler FSM; strobes default low so every pulse lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rd_en_r      <= 1'b0;
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      tx_done_r    <= 1'b0;
      sched_busy_r <= 1'b0;
      start_err_r  <= 1'b0;
      to_cnt_r     <= {TO_W{1'b0}};
      gap_cnt_r    <= {GAP_WIDTH{1'b0}};
    end else begin
      rd_en_r    <= 1'b0;
      tx_start_r <= 1'b0;
      tx_done_r  <= 1'b0;
      // A timeout assigned later in this block overrides the clear.
      if (err_clr) begin
        start_err_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (en && !empty_tx && !tx_busy) begin
            state_r      <= POP;
            rd_en_r      <= 1'b1;
            sched_busy_r <= 1'b1;
          end
        end
        POP: begin
          state_r <= LOAD;
        end
        LOAD: begin
          tx_data_r  <= tx_dout_fifo[7:0];
          tx_start_r <= 1'b1;
          state_r    <= START;
        end
        START: begin
          to_cnt_r <= {TO_W{1'b0}};
          state_r  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_r <= WAIT_DONE;
          end else if (to_cnt_r == TO_LAST) begin
            start_err_r  <= 1'b1;
            to_cnt_r     <= {TO_W{1'b0}};
            sched_busy_r <= 1'b0;
            state_r      <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            tx_done_r <= 1'b1;
            if (gap_cycles != {GAP_WIDTH{1'b0}}) begin
              gap_cnt_r <= gap_cycles;
              state_r   <= GAP;
            end else begin
              sched_busy_r <= 1'b0;
              state_r      <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt_r <= GAP_WIDTH'(1)) begin
            gap_cnt_r    <= {GAP_WIDTH{1'b0}};
            sched_busy_r <= 1'b0;
            state_r      <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1);
          end
        end
        default: begin
          sched_busy_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign rd_en      = rd_en_r;
  assign tx_start   = tx_start_r;
  assign tx_data    = tx_data_r;
  assign tx_done    = tx_done_r;
  assign sched_busy = sched_busy_r;
  assign start_err  = start_err_r;

`ifdef UART_TX_SCHED_STATS_EN
  logic [15:0] frame_cnt_r;
  logic        done_evt_s;

  assign done_evt_s = (state_r == WAIT_DONE) && !tx_busy;

  // Frame counter advances together with the tx_done pulse and saturates.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      frame_cnt_r <= 16'h0000;
    end else if (done_evt_s && (frame_cnt_r != 16'hFFFF)) begin
      frame_cnt_r <= frame_cnt_r + 16'h0001;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: FIFO and transmitter models, a vector table, hand-written corner
// sequences and randomized bursts checked against a cycle schedule derived from the frame rules.

module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  gap_cycles;
  logic        empty_tx;
  logic [15:0] tx_dout_fifo;
  logic        rd_en;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        sched_busy;
  logic        start_err;
  logic        err_clr;
`ifdef UART_TX_SCHED_STATS_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  uart_tx_sched dut (
    .clk(clk), .rst(rst), .en(en), .gap_cycles(gap_cycles), .empty_tx(empty_tx),
    .tx_dout_fifo(tx_dout_fifo), .rd_en(rd_en), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .tx_done(tx_done), .sched_busy(sched_busy), .start_err(start_err),
    .err_clr(err_clr)
`ifdef UART_TX_SCHED_STATS_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_from = 0;
  int          busy_to = 0;
  logic [15:0] fifo_q[$];
  int          cfg_d[$];
  int          cfg_l[$];

  typedef struct {
    logic [15:0] word;
    logic [7:0]  gap;
    int          d;
    int          l;
    logic [7:0]  exp_data;
    int          exp_done;
    logic        exp_err;
    int          exp_busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: FIFO data follows rd_en by one cycle; the transmitter goes busy d cycles
  // after each tx_start for l cycles (d < 0 means it never goes busy).
  task automatic step();
    logic rd_prev;
    int   d;
    int   l;
    rd_prev = rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_prev && fifo_q.size() > 0) tx_dout_fifo = fifo_q.pop_front();
    empty_tx = (fifo_q.size() == 0);
    if (tx_start) begin
      d = -1;
      l = 0;
      if (cfg_d.size() > 0) begin
        d = cfg_d.pop_front();
        l = cfg_l.pop_front();
      end
      if (d < 0) begin
        busy_from = 0;
        busy_to   = 0;
      end else begin
        busy_from = cyc + d;
        busy_to   = cyc + d + l;
      end
    end
    tx_busy = (cyc >= busy_from) && (cyc < busy_to);
  endtask

  task automatic push(input logic [15:0] word, input int d, input int l);
    fifo_q.push_back(word);
    cfg_d.push_back(d);
    cfg_l.push_back(l);
    empty_tx = 1'b0;
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 700; k++) begin
      if (!sched_busy && cyc >= busy_to && fifo_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("quiet", 32'(ok), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    int          n_rd, rd_c, n_st, st_c, n_dn, n_bz, s, n, g, c0, last;
    logic [7:0]  st_data, e_dat;
    logic        e_rd, e_st, e_dn, e_bz;
    bit          ok, found;
    int          rdc[5], sc[5], fc[5], dd[5], ll[5];
    logic [7:0]  bb[5];

    vecs[0] = '{16'hAB55, 8'd0,   2,  20, 8'h55, 1, 1'b0, 25};
    vecs[1] = '{16'h12A5, 8'd4,   1,  3,  8'hA5, 1, 1'b0, 11};
    vecs[2] = '{16'hFF3C, 8'd255, 3,  1,  8'h3C, 1, 1'b0, 262};
    vecs[3] = '{16'h00FF, 8'd1,   15, 2,  8'hFF, 1, 1'b0, 21};
    vecs[4] = '{16'h8081, 8'd0,   -1, 0,  8'h81, 0, 1'b1, 18};
    vecs[5] = '{16'h5A42, 8'd3,   16, 3,  8'h42, 0, 1'b1, 18};

    rst = 1'b1; en = 1'b0; gap_cycles = 8'd0; empty_tx = 1'b1;
    tx_dout_fifo = 16'h0000; tx_busy = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    check("reset_outs", 32'({rd_en, tx_start, tx_done, sched_busy, start_err, tx_data}), 32'd0);
    rst = 1'b0;
    step();
    check("reset_idle", 32'(sched_busy), 32'd0);

    // Single-frame table.
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].word, vecs[i].d, vecs[i].l);
      gap_cycles = vecs[i].gap;
      en = 1'b1;
      n_rd = 0; rd_c = 0; n_st = 0; st_c = 0; n_dn = 0; n_bz = 0; st_data = 8'h00; ok = 1'b0;
      for (int k = 0; k < 700; k++) begin
        step();
        if (rd_en) begin n_rd++; rd_c = cyc; end
        if (tx_start) begin n_st++; st_c = cyc; st_data = tx_data; end
        if (tx_done) n_dn++;
        if (sched_busy) n_bz++;
        if (n_rd > 0 && !sched_busy && cyc >= busy_to) begin ok = 1'b1; break; end
      end
      check("vec_finish", 32'(ok), 32'd1);
      repeat (3) begin
        step();
        if (rd_en) n_rd++;
        if (tx_start) n_st++;
        if (tx_done) n_dn++;
      end
      check("vec_rd_cnt", 32'(n_rd), 32'd1);
      check("vec_start_cnt", 32'(n_st), 32'd1);
      check("vec_start_lat", 32'(st_c - rd_c), 32'd2);
      check("vec_data", 32'(st_data), 32'(vecs[i].exp_data));
      check("vec_done_cnt", 32'(n_dn), 32'(vecs[i].exp_done));
      check("vec_err", 32'(start_err), 32'(vecs[i].exp_err));
      check("vec_busy_len", 32'(n_bz), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_err) begin
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("vec_err_clr", 32'(start_err), 32'd0);
      end
    end

    // Timeout with err_clr held: the set wins on the timeout edge, the clear acts next.
    err_clr = 1'b1;
    push(16'h0077, -1, 0);
    found = 1'b0; s = cyc;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tx_start) begin found = 1'b1; s = cyc; break; end
    end
    check("setwin_start", 32'(found), 32'd1);
    while (cyc < s + 15) step();
    check("setwin_pre_err", 32'(start_err), 32'd0);
    check("setwin_pre_busy", 32'(sched_busy), 32'd1);
    step();
    check("setwin_err", 32'(start_err), 32'd1);
    check("setwin_idle", 32'(sched_busy), 32'd0);
    step();
    check("setwin_clr", 32'(start_err), 32'd0);
    err_clr = 1'b0;

    // Reset while waiting for busy.
    push(16'h0099, -1, 0);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tx_start) begin found = 1'b1; break; end
    end
    check("rstmid_start", 32'(found), 32'd1);
    repeat (3) step();
    rst = 1'b1;
    step();
    check("rstmid_outs", 32'({rd_en, tx_start, tx_done, sched_busy, start_err, tx_data}), 32'd0);
    rst = 1'b0;
    n_rd = 0;
    repeat (30) begin
      step();
      if (rd_en || tx_start || tx_done || start_err) n_rd++;
    end
    check("rstmid_no_pulse", 32'(n_rd), 32'd0);
    check("rstmid_idle", 32'(sched_busy), 32'd0);

    // en dropped mid-frame with a second byte queued.
    push(16'h0011, 2, 10);
    push(16'h0022, 2, 10);
    gap_cycles = 8'd2;
    en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (tx_busy && sched_busy) begin found = 1'b1; break; end
    end
    check("endrop_busy", 32'(found), 32'd1);
    en = 1'b0;
    n_rd = 0; n_dn = 0;
    repeat (60) begin
      step();
      if (rd_en) n_rd++;
      if (tx_done) n_dn++;
    end
    check("endrop_done", 32'(n_dn), 32'd1);
    check("endrop_no_pop", 32'(n_rd), 32'd0);
    check("endrop_idle", 32'(sched_busy), 32'd0);
    en = 1'b1;
    found = 1'b0; st_data = 8'h00;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tx_start) begin found = 1'b1; st_data = tx_data; break; end
    end
    check("endrop_resume", 32'(found), 32'd1);
    check("endrop_byte2", 32'(st_data), 32'h22);
    wait_quiet();

    // Randomized bursts against a schedule computed from the frame rules.
    for (int bi = 0; bi < 12; bi++) begin
      wait_quiet();
      step();
      if (bi == 0) begin
        n = 3; g = 4;
        bb[0] = 8'hA5; bb[1] = 8'h3C; bb[2] = 8'hFF;
        for (int k = 0; k < 3; k++) begin dd[k] = 2; ll[k] = 5; end
      end else begin
        n = int'($urandom_range(1, 5));
        g = int'($urandom_range(0, 6));
        for (int k = 0; k < n; k++) begin
          bb[k] = 8'($urandom);
          dd[k] = int'($urandom_range(1, 6));
          ll[k] = int'($urandom_range(1, 8));
        end
      end
      c0 = cyc;
      for (int k = 0; k < n; k++) begin
        push({8'($urandom), bb[k]}, dd[k], ll[k]);
        rdc[k] = (k == 0) ? c0 + 1 : fc[k-1] + g + 2;
        sc[k]  = rdc[k] + 2;
        fc[k]  = sc[k] + dd[k] + ll[k];
      end
      gap_cycles = 8'(g);
      en = 1'b1;
      last = fc[n-1] + g + 3;
      while (cyc < last) begin
        step();
        e_rd = 1'b0; e_st = 1'b0; e_dn = 1'b0; e_bz = 1'b0; e_dat = 8'h00;
        for (int k = 0; k < n; k++) begin
          if (cyc == rdc[k]) e_rd = 1'b1;
          if (cyc == sc[k]) e_st = 1'b1;
          if (cyc == fc[k] + 1) e_dn = 1'b1;
          if (cyc >= rdc[k] && cyc <= fc[k] + g) e_bz = 1'b1;
          if (cyc >= sc[k]) e_dat = bb[k];
        end
        check("burst_cycle",
              32'({rd_en, tx_start, tx_done, sched_busy, start_err, (cyc >= sc[0]) ? tx_data : 8'h00}),
              32'({e_rd, e_st, e_dn, e_bz, 1'b0, e_dat}));
      end
    end

`ifdef UART_TX_SCHED_STATS_EN
    wait_quiet();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    gap_cycles = 8'd0;
    for (int k = 0; k < 5; k++) push(16'h0100 + 16'(k), 1, 2);
    wait_quiet();
    step();
    check("frame_cnt", 32'(frame_cnt), 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
